// File: rtl/dm_sized_if.sv
// Request/response bus between the MEM stage and dm_sized.
// Master drives requests; slave returns ready and responses.
interface dm_sized_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  req;
  logic                  we;
  logic [1:0]            size;
  logic                  uns;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           din;
  logic                  ready;
  logic                  resp_valid;
  logic [31:0]           dout;
  logic                  err;

  modport master (
    output req, we, size, uns, addr, din,
    input  ready, resp_valid, dout, err
  );

  modport slave (
    input  req, we, size, uns, addr, din,
    output ready, resp_valid, dout, err
  );
endinterface

// File: rtl/dm_sized.sv
// Sized data memory: byte/half/word access, zero-clear sweep
// after reset, and a fixed-latency in-order response pipeline.
module dm_sized #(
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  dm_sized_if.slave  bus
);
  localparam int IW    = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** IW;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [IW-1:0] cnt_q;
  logic [IW-1:0] cnt_d;
  logic          clr_we;
  logic          rdy;

  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic [1:0]    lane;
  logic [IW-1:0] idx;
  logic [31:0]   rword;
  logic [31:0]   rsh;
  logic [7:0]    bsel;
  logic [15:0]   hsel;
  logic          acc_err;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [31:0]   ld;

  logic          vld_q [RD_LATENCY];
  logic [31:0]   dat_q [RD_LATENCY];
  logic          er_q  [RD_LATENCY];

  assign accept = bus.req && rdy;
  assign lane   = bus.addr[1:0];
  assign idx    = bus.addr[ADDR_WIDTH-1:2];
  assign rword  = mem[idx];
  assign rsh    = rword >> {lane, 3'b000};
  assign bsel   = rsh[7:0];
  assign hsel   = bus.addr[1] ? rword[31:16] : rword[15:0];

  // Sweep state and word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sweep clears one word per cycle, then the block stays ready.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    rdy     = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == IW'(DEPTH - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        rdy = 1'b1;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // Alignment check, lane enables and replicated store data.
  always_comb begin
    acc_err = 1'b0;
    be      = 4'b0000;
    wdata   = '0;
    unique case (1'b1)
      (bus.size == 2'b00): begin
        be    = 4'b0001 << lane;
        wdata = {4{bus.din[7:0]}};
      end
      (bus.size == 2'b01): begin
        wdata = {2{bus.din[15:0]}};
        if (bus.addr[0]) begin
          acc_err = 1'b1;
        end else begin
          be = bus.addr[1] ? 4'b1100 : 4'b0011;
        end
      end
      (bus.size == 2'b10): begin
        wdata = bus.din;
        if (lane != 2'b00) begin
          acc_err = 1'b1;
        end else begin
          be = 4'b1111;
        end
      end
      default: begin
        acc_err = 1'b1;
      end
    endcase
  end

  // Load extraction with sign/zero extension.
  always_comb begin
    ld = '0;
    unique case (1'b1)
      (bus.size == 2'b00): begin
        ld = bus.uns ? {24'b0, bsel}
                     : {{24{bsel[7]}}, bsel};
      end
      (bus.size == 2'b01): begin
        ld = bus.uns ? {16'b0, hsel}
                     : {{16{hsel[15]}}, hsel};
      end
      (bus.size == 2'b10): begin
        ld = rword;
      end
      default: begin
        ld = '0;
      end
    endcase
    if (bus.we || acc_err) begin
      ld = '0;
    end
  end

  // Array write port: sweep clears, else lane-masked store.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt_q] <= '0;
    end else if (accept && bus.we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Response pipeline; data only moves with a valid so the
  // last stage holds its value between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= '0;
        er_q[i]  <= 1'b0;
      end
    end else begin
      vld_q[0] <= accept;
      if (accept) begin
        dat_q[0] <= ld;
        er_q[0]  <= acc_err;
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
          er_q[i]  <= er_q[i-1];
        end
      end
    end
  end

  assign bus.ready      = rdy;
  assign bus.resp_valid = vld_q[RD_LATENCY-1];
  assign bus.dout       = dat_q[RD_LATENCY-1];
  assign bus.err        = er_q[RD_LATENCY-1];
endmodule

// File: tb/tb_dm_sized.sv
// Bench for dm_sized: table vectors, hand sequences and
// random traffic against a byte-array reference model.
module tb_dm_sized;
  localparam int AW    = 6;
  localparam int LAT   = 2;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  dm_sized_if #(.ADDR_WIDTH(AW)) bus ();

  dm_sized #(
    .ADDR_WIDTH(AW),
    .RD_LATENCY(LAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    int          due;
    logic [31:0] d;
    logic        e;
  } exp_t;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [5:0]  addr;
    logic [31:0] din;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          sweep_left = DEPTH;
  logic [7:0]  mb [64];
  exp_t        q [$];
  logic        last_rv;
  logic [31:0] last_d;
  logic        last_e;
  vec_t        tbl [15];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)",
               nm, act, exp_v, cyc);
    end
  endtask

  function automatic void model(
    input  logic        we,
    input  logic [1:0]  sz,
    input  logic        uns,
    input  logic [5:0]  a,
    input  logic [31:0] din,
    output logic [31:0] d,
    output logic        e
  );
    int          n;
    logic [31:0] v;
    e = (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
        (sz == 2'd2 && a[1:0] != 2'b00);
    d = '0;
    if (e) return;
    n = 1 << sz;
    if (we) begin
      for (int i = 0; i < n; i++)
        mb[(int'(a) + i) % 64] = din[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < n; i++)
        v = v | (32'(mb[(int'(a) + i) % 64]) << (8 * i));
      if (!uns && n < 4 && v[8*n-1])
        v = v | (32'hFFFF_FFFF << (8 * n));
      d = v;
    end
  endfunction

  task automatic drive(input logic r, input logic we,
                       input logic [1:0] sz, input logic uns,
                       input logic [5:0] a, input logic [31:0] din);
    bus.req  = r;
    bus.we   = we;
    bus.size = sz;
    bus.uns  = uns;
    bus.addr = a;
    bus.din  = din;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b10, 1'b0, 6'h0, 32'h0);
  endtask

  task automatic step();
    exp_t        x;
    logic [31:0] d;
    logic        e;
    @(posedge clk);
    cyc++;
    if (rst_n && bus.req && sweep_left == 0) begin
      model(bus.we, bus.size, bus.uns, bus.addr, bus.din, d, e);
      x.due = cyc + LAT - 1;
      x.d   = d;
      x.e   = e;
      q.push_back(x);
    end
    if (rst_n && sweep_left > 0) sweep_left--;
    #1;
    chk("ready", 32'(bus.ready), 32'(sweep_left == 0));
    last_rv = bus.resp_valid;
    last_d  = bus.dout;
    last_e  = bus.err;
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("resp_valid", 32'(bus.resp_valid), 32'd1);
      if (bus.resp_valid) begin
        chk("dout", bus.dout, q[0].d);
        chk("err", 32'(bus.err), 32'(q[0].e));
      end
      void'(q.pop_front());
    end else begin
      chk("resp_valid_idle", 32'(bus.resp_valid), 32'd0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_dout", bus.dout, 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    q.delete();
    foreach (mb[i]) mb[i] = 8'h00;
    sweep_left = DEPTH;
    idle();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic sweep_wait();
    int n;
    n = 0;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 6'h3C, 32'h0);
    while (!bus.ready && n < 40) begin
      step();
      n++;
    end
    idle();
    chk("sweep_cycles", 32'(n), 32'(DEPTH));
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int  acc;
    bit  got;
    drive(1'b1, v.we, v.size, v.uns, v.addr, v.din);
    step();
    acc = cyc;
    idle();
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      step();
      if (last_rv) got = 1'b1;
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: no response within 6 cycles", nm);
    end else begin
      chk({nm, "_lat"}, 32'(cyc - acc + 1), 32'(LAT));
      chk({nm, "_dout"}, last_d, v.exp_d);
      chk({nm, "_err"}, 32'(last_e), 32'(v.exp_e));
    end
  endtask

  initial begin
    int first;
    int last;
    int cnt;
    tbl[0]  = '{1'b0, 2'd2, 1'b0, 6'h3C, 32'h0, 32'h0000_0000, 1'b0};
    tbl[1]  = '{1'b1, 2'd2, 1'b0, 6'h20, 32'h8765_4321, 32'h0, 1'b0};
    tbl[2]  = '{1'b0, 2'd2, 1'b0, 6'h20, 32'h0, 32'h8765_4321, 1'b0};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 6'h23, 32'h0, 32'hFFFF_FF87, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 1'b1, 6'h23, 32'h0, 32'h0000_0087, 1'b0};
    tbl[5]  = '{1'b0, 2'd1, 1'b0, 6'h22, 32'h0, 32'hFFFF_8765, 1'b0};
    tbl[6]  = '{1'b0, 2'd1, 1'b1, 6'h20, 32'h0, 32'h0000_4321, 1'b0};
    tbl[7]  = '{1'b1, 2'd0, 1'b0, 6'h21, 32'h0000_00AA, 32'h0, 1'b0};
    tbl[8]  = '{1'b0, 2'd2, 1'b0, 6'h20, 32'h0, 32'h8765_AA21, 1'b0};
    tbl[9]  = '{1'b1, 2'd1, 1'b0, 6'h22, 32'h0000_1234, 32'h0, 1'b0};
    tbl[10] = '{1'b0, 2'd2, 1'b0, 6'h20, 32'h0, 32'h1234_AA21, 1'b0};
    tbl[11] = '{1'b1, 2'd1, 1'b0, 6'h21, 32'hFFFF_FFFF, 32'h0, 1'b1};
    tbl[12] = '{1'b0, 2'd2, 1'b0, 6'h22, 32'h0, 32'h0, 1'b1};
    tbl[13] = '{1'b0, 2'd3, 1'b0, 6'h20, 32'h0, 32'h0, 1'b1};
    tbl[14] = '{1'b0, 2'd2, 1'b0, 6'h20, 32'h0, 32'h1234_AA21, 1'b0};

    idle();
    #3;
    do_reset();
    sweep_wait();

    for (int i = 0; i < 15; i++)
      run_vec(tbl[i], $sformatf("vec%0d", i));

    // store then load on the very next cycle
    drive(1'b1, 1'b1, 2'd2, 1'b0, 6'h24, 32'hCAFE_F00D);
    step();
    drive(1'b1, 1'b0, 2'd2, 1'b0, 6'h24, 32'h0);
    step();
    idle();
    for (int k = 0; k < 3; k++) step();

    // four back-to-back loads, four consecutive responses
    first = -1;
    last  = -1;
    cnt   = 0;
    for (int k = 0; k < 8; k++) begin
      if (k < 4)
        drive(1'b1, 1'b0, 2'd2, 1'b0, 6'(8'h20 + 4 * k), 32'h0);
      else
        idle();
      step();
      if (last_rv) begin
        if (first < 0) first = cyc;
        last = cyc;
        cnt++;
      end
    end
    chk("b2b_count", 32'(cnt), 32'd4);
    chk("b2b_span", 32'(last - first), 32'd3);

    // reset while loads are in flight
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 2'd2, 1'b0, 6'(8'h20 + 4 * k), 32'h0);
      step();
    end
    chk("abort_inflight", 32'(last_rv), 32'd1);
    do_reset();
    sweep_wait();
    run_vec('{1'b0, 2'd2, 1'b0, 6'h20, 32'h0, 32'h0, 1'b0},
            "post_reset");

    // random traffic against the reference model
    for (int k = 0; k < 500; k++) begin
      logic [1:0] sz;
      logic [5:0] a;
      sz = ($urandom_range(0, 9) == 0) ? 2'd3
                                        : 2'($urandom_range(0, 2));
      a  = 6'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      drive(1'($urandom_range(0, 9) < 7), 1'($urandom),
            sz, 1'($urandom), a, $urandom);
      step();
    end
    idle();
    for (int k = 0; k < 4; k++) step();
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dm_sized.md
Name: dm_sized

Overview:
- Parametrised data memory for the MIPS datapath; next generation of the fixed 1 KB word-only data memory.
- Adds byte/halfword/word stores and loads with sign or zero extension, and misalignment detection.
- Adds a configurable read-latency pipeline with a request/response handshake.
- Adds a hardware zero-clear sweep after every reset.
- Sits between the MEM stage and the memory array; one request per cycle.

Parameters:
ADDR_WIDTH, 10, byte-address width; array holds DEPTH = 2**(ADDR_WIDTH-2) 32-bit words (ADDR_WIDTH >= 3)
RD_LATENCY, 1, cycles from accepted request to response (1..4)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req  in  1  request valid
we  in  1  1 = store, 0 = load
size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
uns  in  1  load zero-extends when 1, sign-extends when 0; ignored for word and for stores
addr  in  ADDR_WIDTH  byte address
din  in  32  store data; byte uses din[7:0], halfword uses din[15:0]
ready  out  1  block accepts req this cycle
resp_valid  out  1  response valid, one cycle per accepted request
dout  out  32  load result, valid with resp_valid
err  out  1  misaligned or illegal access, valid with resp_valid

Behaviour:
- Clock is clk. Reset is rst_n: asynchronous, active-low.
- Reset values: ready 0, resp_valid 0, dout 0, err 0. Sweep counter is 0 and state is CLEAR. All pipeline stages are invalid. The array is not reset directly.
- FSM states:
  - CLEAR: ready=0. On each cycle, writes 0 to word[cnt] and increments cnt. After the cycle writing word DEPTH-1, moves to RUN. The sweep therefore takes exactly DEPTH cycles after rst_n rises.
  - RUN: ready=1 permanently.
- Accept: a request is accepted when req && ready at a rising edge. If ready=0, req is ignored and no response is ever produced for it.
- Byte order is little-endian:
  - Byte lane = addr[1:0]; lane 0 is bits 7:0.
  - Halfword at addr[1]=0 is bits 15:0; at addr[1]=1 it is bits 31:16.
  - Word index = addr[ADDR_WIDTH-1:2].
- Alignment rules:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=00.
  - size=11 is always illegal.
  - A violation sets err=1 and dout=0 in the response. No array write occurs.
- Stores:
  - The array is updated at the accept edge, on the selected lanes only; other lanes keep their value.
  - The store still produces a response after RD_LATENCY cycles, with dout=0 and err per the alignment rules.
- Loads:
  - The array is read at the accept edge, so the load sees every store accepted on earlier edges.
  - The result is extracted and extended per size/uns, then carried through the remaining stages.
  - resp_valid asserts exactly RD_LATENCY cycles after the accept edge.
  - RD_LATENCY=1 means the response is visible in the cycle immediately after acceptance.
- Throughput: one request per cycle, with no bubbles. Responses return in request order.
- dout and err hold their last values when resp_valid=0. Bench checks them only while resp_valid=1.
- Addresses wrap within ADDR_WIDTH; there is no out-of-range condition.
- Reset mid-operation:
  - rst_n low immediately forces resp_valid=0 and discards in-flight responses.
  - On release, the CLEAR sweep restarts from word 0, so all prior contents read as 0 afterwards.
- Simultaneous events: reset dominates everything.

Test Plan:
All scenarios use ADDR_WIDTH=6 (DEPTH=16) and RD_LATENCY=2.
1. Release rst_n -> ready low for exactly 16 cycles, then high. Load word 0x3C -> resp_valid 2 cycles after accept, dout 0x00000000, err 0.
2. Store word 0x20 with din 0x87654321, then load word 0x20 on the next cycle -> dout 0x87654321, err 0. Response appears 2 cycles after the load's accept.
3. Loads from the value written in scenario 2:
   - byte 0x23 with uns=0 -> 0xFFFFFF87
   - byte 0x23 with uns=1 -> 0x00000087
   - halfword 0x22 with uns=0 -> 0xFFFF8765
   - halfword 0x20 with uns=1 -> 0x00004321
4. Store byte 0x21 with din 0x000000AA, then load word 0x20 -> 0x8765AA21. Store halfword 0x22 with din 0x00001234, then load word 0x20 -> 0x1234AA21.
5. Error cases, each giving err=1 and dout=0:
   - store halfword 0x21
   - load word 0x22
   - size=11 at 0x20
   A following load word 0x20 still returns 0x1234AA21.
6. Back-to-back and reset-abort:
   - Four loads on consecutive cycles (0x20, 0x24, 0x28, 0x2C) -> four consecutive resp_valid cycles, in order.
   - Drop rst_n while loads are in flight -> resp_valid 0 immediately.
   - After release, ready stays low for 16 cycles, then load word 0x20 -> 0x00000000.
